// File: rtl/ram2_arbiter.sv
// Single-port program SRAM controller shared between instruction fetch and
// data accesses. Data wins arbitration unless fetch has been starved for
// BURST_LIMIT consecutive data grants. Writes take a three-cycle
// setup/strobe/hold sequence so the SRAM sees a clean WE pulse.
module ram2_arbiter #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BURST_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              if_stall,
  // Data port
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  // SRAM pins
  output logic [ADDR_W-1:0] Ram2Addr,
  inout  wire  [DATA_W-1:0] Ram2Data,
  output logic              Ram2OE,
  output logic              Ram2WE,
  output logic              Ram2EN
);

  localparam int unsigned CntW = $clog2(BURST_LIMIT + 1);
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST_LIMIT);

  // One-hot encoding; bit 4 is DW2 and directly produces the WE strobe.
  typedef enum logic [5:0] {
    StIdle  = 6'b000001,
    StIread = 6'b000010,
    StDread = 6'b000100,
    StDw1   = 6'b001000,
    StDw2   = 6'b010000,
    StDw3   = 6'b100000
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              data_grant;
  logic              bus_oe;

  // Next-state and grant decision; DW1/DW2 are locked into the write sequence.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    data_grant = 1'b0;
    unique case (state_q)
      StDw1: state_d = StDw2;
      StDw2: state_d = StDw3;
      default: begin
        if (if_req && (burst_q == BurstMax)) begin
          state_d = StIread;
        end else if (mem_we) begin
          state_d    = StDw1;
          data_grant = 1'b1;
        end else if (mem_re) begin
          state_d    = StDread;
          data_grant = 1'b1;
        end else if (if_req) begin
          state_d = StIread;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    // Starvation counter only tracks data grants made while a fetch waits.
    if (!if_req) begin
      burst_d = '0;
    end else if (state_d == StIread) begin
      burst_d = '0;
    end else if (data_grant && (burst_q != BurstMax)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  // State, starvation counter and latched data request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      burst_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      if (data_grant) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

  // SRAM control pins and requester responses, decoded from the current state.
  always_comb begin
    Ram2Addr  = '0;
    Ram2EN    = 1'b1;
    Ram2OE    = 1'b1;
    if_inst   = '0;
    if_valid  = 1'b0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    unique case (state_q)
      StIread: begin
        Ram2Addr = if_addr;
        Ram2EN   = 1'b0;
        Ram2OE   = 1'b0;
        if_inst  = Ram2Data;
        if_valid = 1'b1;
      end
      StDread: begin
        Ram2Addr  = addr_q;
        Ram2EN    = 1'b0;
        Ram2OE    = 1'b0;
        mem_rdata = Ram2Data;
        mem_ack   = 1'b1;
      end
      StDw1, StDw2: begin
        Ram2Addr = addr_q;
        Ram2EN   = 1'b0;
      end
      StDw3: begin
        Ram2Addr = addr_q;
        Ram2EN   = 1'b0;
        mem_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  // WE straight from the DW2 flop: no decode glitches, released by async reset.
  assign Ram2WE    = ~state_q[4];
  assign bus_oe    = state_q[3] | state_q[4] | state_q[5];
  assign Ram2Data  = bus_oe ? wdata_q : {DATA_W{1'bz}};

  assign if_stall  = if_req & ~if_valid;
  assign mem_stall = (mem_re | mem_we) & ~mem_ack;

endmodule

// File: tb/tb_ram2_arbiter.sv
// Directed bench for ram2_arbiter with a simple asynchronous SRAM model.
// Requesters update their inputs on the falling edge after seeing valid/ack,
// so the arbiter's next grant decision sees the following request.
module tb_ram2_arbiter;

  localparam int unsigned ADDR_W      = 18;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BURST_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req, mem_re, mem_we;
  logic [ADDR_W-1:0] if_addr, mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] if_inst, mem_rdata;
  logic              if_valid, if_stall, mem_ack, mem_stall;
  logic [ADDR_W-1:0] Ram2Addr;
  wire  [DATA_W-1:0] Ram2Data;
  logic              Ram2OE, Ram2WE, Ram2EN;

  logic [DATA_W-1:0] sram [1024];
  logic              probe_en;
  int unsigned       n_cmp = 0;
  int unsigned       n_err = 0;
  int unsigned       k;

  always #5 clk = ~clk;

  ram2_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .BURST_LIMIT (BURST_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_inst   (if_inst),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .mem_stall (mem_stall),
    .Ram2Addr  (Ram2Addr),
    .Ram2Data  (Ram2Data),
    .Ram2OE    (Ram2OE),
    .Ram2WE    (Ram2WE),
    .Ram2EN    (Ram2EN)
  );

  // SRAM read drive; probe_en puts a sentinel on the bus to expose a DUT driver.
  assign Ram2Data = (!Ram2EN && !Ram2OE && Ram2WE) ? sram[Ram2Addr[9:0]] :
                    (probe_en ? 16'h1234 : 16'hzzzz);

  // SRAM write: commits mid-cycle while WE is low.
  always @(negedge clk) begin
    if (!Ram2EN && !Ram2WE) sram[Ram2Addr[9:0]] = Ram2Data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Fetch completes this cycle with the instruction at the bench's pc; pc advances.
  task automatic fetch_ok(input string tag);
    check(tag, 32'({if_valid, if_stall}), 32'(2'b10));
    check(tag, 32'(if_inst), 32'(16'h1000) + 32'(if_addr));
    if_addr = if_addr + 1'b1;
  endtask

  // Write sequence, one negedge per cycle: OE high, WE 1/0/1, ack in last cycle.
  task automatic write_seq(input string tag, input logic [15:0] data);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check(tag, 32'({Ram2OE, Ram2WE, mem_ack, mem_stall}),
            32'({1'b1, c != 1, c == 2, c != 2}));
      check(tag, 32'(Ram2Data), 32'(data));
    end
    mem_we = 1'b0;
    mem_re = 1'b0;
  endtask

  initial begin
    if_req    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if_addr   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    probe_en  = 1'b0;
    for (int i = 0; i < 1024; i++) sram[i] = 16'(32'h1000 + i);
    sram[10'h100] = 16'h5A5A;

    // Reset values
    #1;
    check("rst_ctl", 32'({Ram2EN, Ram2OE, Ram2WE}), 32'(3'b111));
    check("rst_addr", 32'(Ram2Addr), 32'h0);
    check("rst_flags", 32'({if_valid, mem_ack, mem_stall}), 32'h0);
    check("rst_data", {if_inst, mem_rdata}, 32'h0);

    // Continuous fetch: one IDLE cycle, then one instruction per cycle
    @(negedge clk);
    rst    = 1'b1;
    if_req = 1'b1;
    #1;
    check("idle_stall", 32'({if_valid, if_stall}), 32'(2'b01));
    repeat (8) begin
      @(negedge clk);
      fetch_ok("fetch_stream");
    end

    // Single read steals one cycle from fetch
    mem_re   = 1'b1;
    mem_addr = 18'h00100;
    @(negedge clk);
    check("dread_flags", 32'({mem_ack, if_valid, if_stall, mem_stall}), 32'(4'b1010));
    check("dread_data", 32'(mem_rdata), 32'h5A5A);
    check("dread_addr", 32'(Ram2Addr), 32'h100);
    mem_re = 1'b0;
    @(negedge clk);
    fetch_ok("fetch_resume");

    // Write 0xBEEF to 0x200, then read it back
    mem_we    = 1'b1;
    mem_addr  = 18'h00200;
    mem_wdata = 16'hBEEF;
    write_seq("wr_beef", 16'hBEEF);
    @(negedge clk);
    fetch_ok("fetch_after_wr");
    check("wr_mem", 32'(sram[10'h200]), 32'hBEEF);
    mem_re   = 1'b1;
    mem_addr = 18'h00200;
    @(negedge clk);
    check("rdback", {15'h0, mem_ack, mem_rdata}, {15'h0, 1'b1, 16'hBEEF});
    mem_re = 1'b0;
    @(negedge clk);
    fetch_ok("fetch_after_rd");

    // Six back-to-back reads with fetch pending: D,D,D,D,I,D,D
    k        = 0;
    mem_re   = 1'b1;
    mem_addr = 18'h00300;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("burst_grant", 32'({if_valid, mem_ack}), (c == 4) ? 32'(2'b10) : 32'(2'b01));
      if (mem_ack) begin
        check("burst_data", 32'(mem_rdata), 32'h1300 + k);
        k++;
        mem_addr = 18'(32'h300 + k);
        if (k == 6) mem_re = 1'b0;
      end
      if (if_valid) begin
        check("burst_inst", 32'(if_inst), 32'(16'h1000) + 32'(if_addr));
        if_addr = if_addr + 1'b1;
      end
    end
    check("burst_reads", k, 6);
    @(negedge clk);
    fetch_ok("fetch_after_burst");

    // Read and write together: write wins, no read cycle
    mem_re    = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = 18'h00210;
    mem_wdata = 16'h7E57;
    write_seq("rw_both", 16'h7E57);
    @(negedge clk);
    fetch_ok("fetch_after_rw");
    check("rw_mem", 32'(sram[10'h210]), 32'h7E57);

    // Asynchronous reset in the middle of DW2
    mem_we    = 1'b1;
    mem_addr  = 18'h00220;
    mem_wdata = 16'hA5A5;
    @(negedge clk);
    check("rst_dw1", 32'({Ram2OE, Ram2WE, mem_ack}), 32'(3'b110));
    @(posedge clk);
    #2;
    check("rst_dw2_pre", 32'(Ram2WE), 32'h0);
    rst      = 1'b0;
    probe_en = 1'b1;
    #1;
    check("rst_async_ctl", 32'({Ram2EN, Ram2OE, Ram2WE}), 32'(3'b111));
    check("rst_async_bus", 32'(Ram2Data), 32'h1234);
    check("rst_async_addr", 32'(Ram2Addr), 32'h0);
    check("rst_async_ack", 32'(mem_ack), 32'h0);
    mem_we = 1'b0;
    @(negedge clk);
    check("rst_hold", 32'({mem_ack, if_valid}), 32'h0);
    check("rst_no_write", 32'(sram[10'h220]), 32'h1220);
    probe_en = 1'b0;
    if_addr  = 18'd5;
    if_req   = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    fetch_ok("post_rst_fetch");
    if_req = 1'b0;
    @(negedge clk);
    check("final_idle", 32'({Ram2EN, if_valid, if_stall}), 32'(3'b100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
